// File: rtl/event_stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : evt_pkg
// Brief    : Shared constants for the event-report stream fabric: beat width,
//            source-tag position, marker byte and event-code enumeration.
// Revision : 1.0 - initial release
// ============================================================================
package evt_pkg;

  localparam int AXIS_EVT_W  = 256;
  localparam int EVT_TAG_LSB = 240;

  // Marker byte carried in bits [255:248] of every event report
  localparam logic [7:0] EVT_MARKER = 8'h01;

  typedef enum logic [7:0] {
    UNDERFLOW = 8'd1,
    EVENT_A   = 8'd2,
    EVENT_B   = 8'd3
  } evt_code_e;

endpackage
`default_nettype wire

// File: rtl/event_stream_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin priority picker. Returns the first
//            requesting index at or after (last+1) mod N, with wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] grant,
  output logic         any
);

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);
  localparam logic [W:0]   N_EXT    = (W + 1)'(N);

  logic [W-1:0]   start;
  logic [2*N-1:0] rotated;
  logic [W-1:0]   offset;
  logic [W:0]     sum;

  // Rotate a doubled request vector so the search start sits at bit 0, then
  // take the lowest set bit and map the offset back to an absolute index.
  always_comb begin
    start   = (last == LAST_IDX) ? '0 : last + W'(1);
    rotated = {req, req} >> start;
    offset  = '0;
    any     = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        any    = 1'b1;
        offset = W'(k);
      end
    end
    sum   = {1'b0, start} + {1'b0, offset};
    grant = (sum >= N_EXT) ? W'(sum - N_EXT) : W'(sum);
  end

endmodule
`default_nettype wire

// File: rtl/event_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : event_stream_arbiter
// Brief    : Round-robin merge of N_SRC 256-bit AXI-Stream event sources into
//            one registered output beat stream, tagged with the source index.
//            Optional per-source grant counters when EVT_ARB_STATS_EN is
//            defined (adds clear_stats input and grant_count output).
// Revision : 1.0 - initial release
// ============================================================================
module event_stream_arbiter
  import evt_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int SRC_W   = 4,
  parameter int TAG_LSB = EVT_TAG_LSB
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXIS_EVT_W*N_SRC-1:0]   AXIS_IN_TDATA,
  input  logic [N_SRC-1:0]              AXIS_IN_TVALID,
  output logic [N_SRC-1:0]              AXIS_IN_TREADY,
  output logic [AXIS_EVT_W-1:0]         AXIS_OUT_TDATA,
  output logic                          AXIS_OUT_TVALID,
  input  logic                          AXIS_OUT_TREADY,
`ifdef EVT_ARB_STATS_EN
  input  logic                          clear_stats,
  output logic [32*N_SRC-1:0]           grant_count,
`endif
  output logic [SRC_W-1:0]              last_grant
);

  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_SRC - 1);

  logic                  out_free;
  logic                  any_valid;
  logic                  accept_ok;
  logic [SRC_W-1:0]      pick;
  logic [AXIS_EVT_W-1:0] sel_data;
  logic [AXIS_EVT_W-1:0] tagged_data;

  // Output slot is free when empty or being drained this cycle
  assign out_free  = !AXIS_OUT_TVALID || AXIS_OUT_TREADY;
  assign accept_ok = out_free && any_valid && !rst;

  rr_pick #(
    .N (N_SRC),
    .W (SRC_W)
  ) u_rr_pick (
    .req   (AXIS_IN_TVALID),
    .last  (last_grant),
    .grant (pick),
    .any   (any_valid)
  );

  // One-hot ready toward the picked source only when a beat can be taken
  always_comb begin
    AXIS_IN_TREADY = '0;
    for (int i = 0; i < N_SRC; i++) begin
      AXIS_IN_TREADY[i] = accept_ok && (pick == SRC_W'(i));
    end
  end

  // Select the picked source's beat and overwrite its tag byte with the index
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (pick == SRC_W'(i)) begin
        sel_data = AXIS_IN_TDATA[AXIS_EVT_W*i +: AXIS_EVT_W];
      end
    end
    tagged_data                = sel_data;
    tagged_data[TAG_LSB +: 8]  = 8'(pick);
  end

  // Output register: load on accept, empty when free with no requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AXIS_OUT_TVALID <= 1'b0;
      AXIS_OUT_TDATA  <= '0;
      last_grant      <= LAST_IDX;
    end else if (out_free) begin
      if (any_valid) begin
        AXIS_OUT_TDATA  <= tagged_data;
        AXIS_OUT_TVALID <= 1'b1;
        last_grant      <= pick;
      end else begin
        AXIS_OUT_TVALID <= 1'b0;
      end
    end
  end

`ifdef EVT_ARB_STATS_EN
  generate
    for (genvar i = 0; i < N_SRC; i++) begin : g_stats
      logic [31:0] cnt;

      // Saturating per-source accept counter; clear takes priority
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (clear_stats) begin
          cnt <= '0;
        end else if (AXIS_IN_TREADY[i] && AXIS_IN_TVALID[i] && (cnt != 32'hFFFF_FFFF)) begin
          cnt <= cnt + 32'd1;
        end
      end

      assign grant_count[32*i +: 32] = cnt;
    end
  endgenerate
`endif

endmodule
`default_nettype wire
